// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave MM:SS BCD cook timer, keypad entry + countdown.
// Ports: clk, clrn (async low), key_valid/key_digit, start, stop_clear,
// door_closed in; min_tens/min_ones/sec_tens/sec_ones, mag_on, done,
// state out. Optional macro QUICK_START_EN: start in IDLE runs 00:30.
module cook_timer_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST =
    PW'(TICK_DIV - 1);

  state_t        st;
  logic [PW-1:0] presc;
  logic [15:0]   tm;
  logic          time_zero;
  logic          last_sec;
  logic          start_ok;
  logic          key_ok;
  logic          tick;
  logic [3:0]    d_mt, d_mo, d_st, d_so;

  assign tm        = {min_tens, min_ones,
                      sec_tens, sec_ones};
  assign time_zero = (tm == 16'h0000);
  assign last_sec  = (tm == 16'h0001);
  assign start_ok  = door_closed && !time_zero
                     && (sec_tens <= 4'd5);
  assign key_ok    = key_valid
                     && (key_digit <= 4'd9);
  assign tick      = (st == RUN)
                     && (presc == PLAST);
  assign mag_on    = (st == RUN);
  assign state     = st;

  // BCD borrow chain, one second down
  always_comb begin
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      d_so = 4'd9;
      d_st = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        d_st = 4'd5;
        d_mo = min_ones - 4'd1;
        if (min_ones == 4'd0) begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st       <= IDLE;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE, SET: begin
          if (stop_clear) begin
            st       <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start) begin
            if (st == SET && start_ok) begin
              st    <= RUN;
              presc <= '0;
            end
`ifdef QUICK_START_EN
            else if (st == IDLE && door_closed
                     && time_zero) begin
              st       <= RUN;
              presc    <= '0;
              sec_tens <= 4'd3;
            end
`endif
          end else if (key_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key_digit;
            st       <= SET;
          end
        end
        RUN: begin
          // door opening pauses before any tick
          if (stop_clear || !door_closed) begin
            st <= PAUSE;
          end else if (tick) begin
            presc <= '0;
            if (last_sec) begin
              sec_ones <= 4'd0;
              st       <= IDLE;
              done     <= 1'b1;
            end else begin
              min_tens <= d_mt;
              min_ones <= d_mo;
              sec_tens <= d_st;
              sec_ones <= d_so;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (stop_clear) begin
            st       <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start && start_ok) begin
            st <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed + random bench for cook_timer_ctrl.
// Reference keeps the time as a decimal entry and total seconds.
module tb_cook_timer_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_tens, min_ones;
  logic [3:0] sec_tens, sec_ones;
  logic       mag_on, done;
  logic [1:0] state;
  logic [15:0] disp;

  cook_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .clrn(clrn),
    .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear),
    .door_closed(door_closed),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mag_on(mag_on), .done(done), .state(state)
  );

  assign disp = {min_tens, min_ones,
                 sec_tens, sec_ones};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, exp);
    end
  endtask

  // reference model: entry = MMSS as a decimal number
  int m_entry, m_st, m_presc, secs;
  bit m_done;

  function automatic logic [15:0] bcd(int e);
    return {4'(e / 1000), 4'((e / 100) % 10),
            4'((e / 10) % 10), 4'(e % 10)};
  endfunction

  function automatic bit can_start(int e, bit dr);
    return dr && e != 0 && ((e % 100) / 10) <= 5;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_entry = 0; m_st = 0;
      m_presc = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_st == 0 || m_st == 1) begin
        if (stop_clear) begin
          m_st = 0; m_entry = 0;
        end else if (start) begin
          if (m_st == 1
              && can_start(m_entry, door_closed)) begin
            m_st = 2; m_presc = 0;
          end
`ifdef QUICK_START_EN
          else if (m_st == 0 && door_closed) begin
            m_st = 2; m_presc = 0; m_entry = 30;
          end
`endif
        end else if (key_valid && key_digit <= 9) begin
          m_entry = (m_entry * 10 + int'(key_digit))
                    % 10000;
          m_st = 1;
        end
      end else if (m_st == 2) begin
        if (stop_clear || !door_closed) begin
          m_st = 3;
        end else if (m_presc == TD - 1) begin
          m_presc = 0;
          secs = (m_entry / 100) * 60
                 + m_entry % 100 - 1;
          m_entry = (secs / 60) * 100 + secs % 60;
          if (secs == 0) begin
            m_st = 0; m_done = 1;
          end
        end else begin
          m_presc++;
        end
      end else begin
        if (stop_clear) begin
          m_st = 0; m_entry = 0;
        end else if (start
                     && can_start(m_entry, door_closed)) begin
          m_st = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc digits", disp, bcd(m_entry));
      chk("cyc state", state, m_st);
      chk("cyc mag_on", mag_on, m_st == 2);
      chk("cyc done", done, m_done);
    end
  end

  task automatic step(input bit kv, input int kd,
                      input bit s, input bit sc);
    key_valid = kv;
    key_digit = 4'(kd);
    start = s;
    stop_clear = sc;
    @(negedge clk);
    key_valid = 0;
    start = 0;
    stop_clear = 0;
  endtask

  task automatic key(input int d);
    step(1, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int ndone, at;

  initial begin
    @(negedge clk);
    @(negedge clk);
    run_cmp = 1;
    chk("rst digits", disp, 16'h0000);
    chk("rst state", state, 0);
    chk("rst mag_on", mag_on, 0);
    chk("rst done", done, 0);
    #2 clrn = 1;
    @(negedge clk);

    key(1); key(2); key(3);
    chk("entry digits", disp, 16'h0123);
    chk("entry state", state, 1);
    step(0, 0, 0, 1);
    chk("clear digits", disp, 16'h0000);
    chk("clear state", state, 0);

    key(1); key(0); key(0);
    step(0, 0, 1, 0);
    chk("start mag_on", mag_on, 1);
    chk("start state", state, 2);
    idle(4);
    chk("tick1 digits", disp, 16'h0059);
    idle(4);
    chk("tick2 digits", disp, 16'h0058);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    key(0); key(2);
    step(0, 0, 1, 0);
    ndone = 0; at = 0;
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (done === 1'b1) begin
        ndone++; at = k;
      end
    end
    chk("end done count", ndone, 1);
    chk("end done cycle", at, 8);
    chk("end state", state, 0);
    chk("end mag_on", mag_on, 0);
    chk("end digits", disp, 16'h0000);

    key(1); key(5);
    step(0, 0, 1, 0);
    idle(5);
    door_closed = 0;
    idle(1);
    chk("door state", state, 3);
    chk("door mag_on", mag_on, 0);
    chk("door digits", disp, 16'h0014);
    idle(3);
    chk("frozen digits", disp, 16'h0014);
    step(0, 0, 1, 0);
    chk("open start state", state, 3);
    door_closed = 1;
    idle(1);
    step(0, 0, 1, 0);
    chk("resume state", state, 2);
    idle(2);
    chk("resume hold digits", disp, 16'h0014);
    idle(1);
    chk("resume tick digits", disp, 16'h0013);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    key(7); key(0);
    step(0, 0, 1, 0);
    chk("bad sec state", state, 1);
    chk("bad sec digits", disp, 16'h0070);
    step(0, 0, 0, 1);

    key(5);
    step(0, 0, 1, 1);
    chk("prio state", state, 0);
    chk("prio digits", disp, 16'h0000);

    key(2);
    step(0, 0, 1, 0);
    idle(2);
    #2 clrn = 0;
    #1;
    chk("arst digits", disp, 16'h0000);
    chk("arst state", state, 0);
    chk("arst mag_on", mag_on, 0);
    chk("arst done", done, 0);
    #1 clrn = 1;
    @(negedge clk);

    step(0, 0, 1, 0);
`ifdef QUICK_START_EN
    chk("quick digits", disp, 16'h0030);
    chk("quick state", state, 2);
`else
    chk("quick digits", disp, 16'h0000);
    chk("quick state", state, 0);
`endif
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)
        door_closed = ~door_closed;
      if ($urandom_range(0, 999) < 3) begin
        #2 clrn = 0;
        #1 clrn = 1;
      end
      step($urandom_range(0, 99) < 25,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 3);
    end

    run_cmp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
